// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: transfer states, error causes and wait-state limit shared by apb_mem_slave
package apb_mem_pkg;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
  typedef enum logic [2:0] {OK, MISALIGN, RANGE, UNWRITTEN, STRB} err_t;
endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: word storage with byte-lane writes and per-word written flags
module apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    strb,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       written
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  // storage keeps its contents across reset; only enabled lanes are updated
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (strb[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
  // a word becomes readable once any of its lanes has been written
  always_ff @(posedge clk)
    if (clr) valid <= '0;
    else if (we && |strb) valid[idx] <= 1'b1;
  assign rdata = mem[idx];
  assign written = valid[idx];
endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB slave fronting a word memory; define APB_MEM_PSTRB_EN for APB4 byte strobes
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << LSB) - 1);
  state_t st, st_nx;
  err_t err;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0] a_addr, s_addr;
  logic [DATA_WIDTH-1:0] a_wdata, mem_rdata, resp;
  logic [NB-1:0] a_strb, s_strb, strb_in;
  logic a_write, s_write, setup, access, ld, we, written, strb_err;
  assign setup = PSEL && !PENABLE;
  assign access = PSEL && PENABLE;
`ifdef APB_MEM_PSTRB_EN
  assign strb_in = PSTRB;
  assign strb_err = !s_write && |s_strb;
`else
  assign strb_in = '1;
  assign strb_err = 1'b0;
`endif
  // checks see live bus values on a setup edge and the snapshot afterwards
  assign s_addr = setup ? PADDR : a_addr;
  assign s_write = setup ? PWRITE : a_write;
  assign s_strb = setup ? strb_in : a_strb;
  // next state and wait counter; any setup sample starts a fresh transfer
  always_comb begin
    st_nx = st;
    cnt_nx = cnt;
    if (setup) begin
      st_nx = (WAIT_STATES == 0) ? READY : WAIT;
      cnt_nx = CNT_W'(WAIT_STATES);
    end else if (st == WAIT && access) begin
      st_nx = (cnt == CNT_W'(1)) ? READY : WAIT;
      cnt_nx = cnt - CNT_W'(1);
    end else if (st != IDLE) begin
      st_nx = IDLE;
    end
  end
  // error cause and response data for the transfer being presented
  always_comb begin
    err = ((s_addr & AMASK) != '0) ? MISALIGN :
          ((s_addr >> (IW + LSB)) != '0) ? RANGE :
          strb_err ? STRB :
          (!s_write && !written) ? UNWRITTEN : OK;
    resp = (err == OK) ? mem_rdata : (err == UNWRITTEN) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  end
  assign ld = (st_nx == READY) && (setup || st == WAIT);
  assign we = PRESET && st == READY && access && a_write && err == OK;
  // transfer state and registered response; response loads only as PREADY rises
  always_ff @(posedge PCLK)
    if (!PRESET) begin
      st <= IDLE;
      cnt <= '0;
      PREADY <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA <= '0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      PREADY <= st_nx == READY;
      PSLVERR <= ld ? err != OK : PSLVERR && st_nx == READY;
      if (ld) PRDATA <= resp;
    end
  // setup-phase snapshot of the request
  always_ff @(posedge PCLK)
    if (setup) begin
      a_addr <= PADDR;
      a_write <= PWRITE;
      a_wdata <= PWDATA;
      a_strb <= strb_in;
    end
  apb_mem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_array (
    .clk(PCLK),
    .clr(!PRESET),
    .we(we),
    .idx(IW'(s_addr >> LSB)),
    .wdata(a_wdata),
    .strb(a_strb),
    .rdata(mem_rdata),
    .written(written)
  );
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: scoreboard bench driving a zero-wait and a three-wait apb_mem_slave
module tb_apb_mem_slave;
  typedef struct packed {logic wr; logic err; logic [31:0] data;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn [2], psel [2], penable [2], pwrite [2], pready [2], pslverr [2];
  logic [31:0] paddr [2], pwdata [2], prdata [2];
  logic [3:0] pstrb [2];
  logic [31:0] mem_m [2][32];
  bit val_m [2][32];
  exp_t q0[$], q1[$];
  int n_chk = 0, n_fail = 0;

  apb_mem_slave #(.WAIT_STATES(0)) u0 (
    .PCLK(clk), .PRESET(rstn[0]), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb[0]),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );
  apb_mem_slave #(.WAIT_STATES(3)) u1 (
    .PCLK(clk), .PRESET(rstn[1]), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb[1]),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  function automatic int ws(int d);
    return d == 0 ? 0 : 3;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // reference: 32 words, 128 bytes, written flags; applied when a transfer is issued
  function automatic exp_t model(int d, bit wr, logic [31:0] a, logic [31:0] wd, logic [3:0] s);
    exp_t e;
    int w;
    w = int'(a / 4);
    e.wr = wr;
    e.err = 1'b1;
    e.data = '0;
    if (a % 4 != 0 || a >= 128) return e;
`ifdef APB_MEM_PSTRB_EN
    if (!wr && s != 0) return e;
`else
    s = 4'hF;
`endif
    if (wr) begin
      for (int i = 0; i < 4; i++) if (s[i]) mem_m[d][w][8*i +: 8] = wd[8*i +: 8];
      if (s != 0) val_m[d][w] = 1'b1;
      e.err = 1'b0;
      return e;
    end
    if (!val_m[d][w]) begin
      e.data = '1;
      return e;
    end
    e.err = 1'b0;
    e.data = mem_m[d][w];
    return e;
  endfunction

  function automatic void push(int d, exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic void check_resp(int d);
    exp_t e;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp%0d: response presented, got none expected", d);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("pslverr%0d", d), {31'b0, pslverr[d]}, {31'b0, e.err});
    if (!e.wr || e.err) chk($sformatf("prdata%0d", d), prdata[d], e.data);
  endfunction

  // monitor: each completing access phase presents one response
  always @(negedge clk) begin
    if (psel[0] && penable[0] && pready[0]) check_resp(0);
    if (psel[1] && penable[1] && pready[1]) check_resp(1);
  end

  task automatic xfer(int d, bit wr, logic [31:0] a, logic [31:0] wd, logic [3:0] s);
    int n;
    n = 0;
    push(d, model(d, wr, a, wd, s));
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = s;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    while (!pready[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency%0d", d), n, ws(d));
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk($sformatf("done%0d", d), {30'b0, pready[d], pslverr[d]}, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      for (int w = 0; w < 32; w++) val_m[d][w] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_pready", {31'b0, pready[d]}, 0);
      chk("rst_pslverr", {31'b0, pslverr[d]}, 0);
      chk("rst_prdata", prdata[d], 0);
      rstn[d] = 1'b1;
    end
    xfer(0, 0, 'h10, 0, 0);
    xfer(0, 1, 'h0C, 'hDEADBEEF, 'hF);
    xfer(0, 0, 'h0C, 0, 0);
    xfer(0, 1, 'h80, 'h1, 'hF);
    xfer(0, 1, 'h06, 'h2, 'hF);
    xfer(0, 0, 'h00, 0, 0);
`ifdef APB_MEM_PSTRB_EN
    xfer(0, 1, 'h04, 'hFFFFFFFF, 'hF);
    xfer(0, 1, 'h04, 'h11223344, 'h5);
    xfer(0, 0, 'h04, 0, 0);
    xfer(0, 0, 'h04, 0, 'h1);
    xfer(0, 1, 'h08, 'h5, 'h0);
    xfer(0, 0, 'h08, 0, 0);
`endif
    xfer(1, 1, 'h14, 'hCAFEF00D, 'hF);
    xfer(1, 0, 'h14, 0, 0);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 'h14; pwdata[1] = 'h0BADBEEF; pstrb[1] = 'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("abort_wait_pready", {31'b0, pready[1]}, 0);
    end
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 'h14; pwdata[1] = 'h0BADF00D; pstrb[1] = 'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_ready_reached", {31'b0, pready[1]}, 1);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_pready", {31'b0, pready[1]}, 0);
    xfer(1, 0, 'h14, 0, 0);
    for (int i = 0; i < 300; i++) begin
      int d, r;
      bit wr;
      logic [31:0] a;
      logic [3:0] s;
      d = int'($urandom_range(1));
      r = int'($urandom_range(9));
      wr = 1'($urandom_range(1));
      a = r == 0 ? 32'($urandom_range(15)) * 4 + 32'($urandom_range(3, 1)) :
          r == 1 ? 128 + 32'($urandom_range(1000)) * 4 : 32'($urandom_range(15)) * 4;
      s = wr ? 4'($urandom_range(15)) : ($urandom_range(7) == 0 ? 4'($urandom_range(15, 1)) : 4'h0);
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      xfer(d, wr, a, $urandom, s);
    end
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 'h20; pwdata[0] = 'h12345678; pstrb[0] = 'hF;
    push(0, '{1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    penable[0] = 1'b1;
    chk("rst_mid_ready", {31'b0, pready[0]}, 1);
    rstn[0] = 1'b0;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    chk("rst_mid_pready", {31'b0, pready[0]}, 0);
    chk("rst_mid_pslverr", {31'b0, pslverr[0]}, 0);
    chk("rst_mid_prdata", prdata[0], 0);
    for (int w = 0; w < 32; w++) val_m[0][w] = 1'b0;
    rstn[0] = 1'b1;
    xfer(0, 0, 'h20, 0, 0);
    xfer(0, 0, 'h0C, 0, 0);
    repeat (3) @(posedge clk);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
